pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 33 +++
 rtl/pipeline_ctrl_hazard.sv | 49 ++++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared constants for the pipeline controller. Holds the FSM
//               state encodings, the register-number width, the stall
//               counter width and the source-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Architectural register number width (R0..R15)
    localparam int REG_W   = 4;
    // Width of the saturating hazard-stall counter
    localparam int STALL_W = 16;

    // Controller FSM encodings
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    // True when a stage writing i_dest would supply one of the ID sources.
    // The second source only counts when the ID instruction reads it.
    function automatic logic src_match(
        input logic [REG_W-1:0] i_dest,
        input logic             i_wb_en,
        input logic [REG_W-1:0] i_src1,
        input logic [REG_W-1:0] i_src2,
        input logic             i_two_src
    );
        return i_wb_en && ((i_dest == i_src1) || (i_two_src && (i_dest == i_src2)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational data-hazard comparator between the ID
//               instruction's sources and the EXE / MEM destinations.
//               Build option FORWARDING_EN: when defined only EXE load-use
//               matches stall; otherwise any EXE or MEM match stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_id_src1,
    input  logic [REG_W-1:0] i_id_src2,
    input  logic             i_id_src_valid,
    input  logic             i_id_two_src,
    input  logic [REG_W-1:0] i_exe_dest,
    input  logic             i_exe_wb_en,
    input  logic             i_exe_mem_read,
    input  logic [REG_W-1:0] i_mem_dest,
    input  logic             i_mem_wb_en,
    output logic             o_hazard
);

    logic w_exe_match;
    logic w_mem_match;

    // Per-stage source matches, qualified by the ID instruction reading a source
    always_comb begin
        w_exe_match = i_id_src_valid &&
                      src_match(i_exe_dest, i_exe_wb_en, i_id_src1, i_id_src2, i_id_two_src);
        w_mem_match = i_id_src_valid &&
                      src_match(i_mem_dest, i_mem_wb_en, i_id_src1, i_id_src2, i_id_two_src);
    end

`ifdef FORWARDING_EN
    // Forwarding covers everything except a load whose data is not back yet
    logic w_unused_mem;
    assign w_unused_mem = w_mem_match;
    assign o_hazard     = w_exe_match && i_exe_mem_read;
`else
    // No forwarding paths: any in-flight producer must drain first
    logic w_unused_ld;
    assign w_unused_ld = i_exe_mem_read;
    assign o_hazard    = w_exe_match || w_mem_match;
`endif

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall / flush controller. Arbitrates data-memory
//               wait freezes, branch flushes and data-hazard bubbles, keeps a
//               sticky memory-timeout flag and a saturating stall counter.
//               Build option FORWARDING_EN selects the hazard rule inside
//               hazard_detect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   id_src1,
    input  logic [REG_W-1:0]   id_src2,
    input  logic               id_src_valid,
    input  logic               id_two_src,
    input  logic [REG_W-1:0]   exe_dest,
    input  logic               exe_wb_en,
    input  logic               exe_mem_read,
    input  logic [REG_W-1:0]   mem_dest,
    input  logic               mem_wb_en,
    input  logic               branch_taken,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               freeze_front,
    output logic               bubble_id,
    output logic               flush_front,
    output logic               freeze_all,
    output logic               mem_timeout_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int                  c_WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_timeout_err;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                w_hazard;
    logic                w_mem_stall;
    logic                w_freeze_all;
    logic                w_flush;
    logic                w_bubble;

    hazard_detect u_hazard (
        .i_id_src1      (id_src1),
        .i_id_src2      (id_src2),
        .i_id_src_valid (id_src_valid),
        .i_id_two_src   (id_two_src),
        .i_exe_dest     (exe_dest),
        .i_exe_wb_en    (exe_wb_en),
        .i_exe_mem_read (exe_mem_read),
        .i_mem_dest     (mem_dest),
        .i_mem_wb_en    (mem_wb_en),
        .o_hazard       (w_hazard)
    );

    // Control priority: memory freeze, then branch flush, then hazard bubble;
    // everything is forced low while reset is held
    always_comb begin
        w_mem_stall  = (r_state == ST_RUN) ? (mem_req && !mem_ready) : !mem_ready;
        w_freeze_all = !rst && w_mem_stall;
        w_flush      = !rst && !w_freeze_all && branch_taken;
        w_bubble     = !rst && !w_freeze_all && !w_flush && w_hazard;
    end

    // Next state: enter the wait on an unready request, leave on ready
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (mem_req && !mem_ready) w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ready)             w_state_nxt = ST_RUN;
            default:                                w_state_nxt = ST_RUN;
        endcase
    end

    // Wait-counter next value: one step per unready MEM_WAIT cycle, saturating
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (r_state == ST_RUN) begin
            w_wait_nxt = '0;
        end else if (!mem_ready && (r_wait_cnt != c_TIMEOUT)) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Wait counter register; held at zero in RUN so each wait starts fresh
    always_ff @(posedge clk) begin
        if (rst) r_wait_cnt <= '0;
        else     r_wait_cnt <= w_wait_nxt;
    end

    // Sticky timeout flag, set on the edge the wait counter reaches the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if ((r_state == ST_MEM_WAIT) && (w_wait_nxt == c_TIMEOUT)) begin
            r_timeout_err <= 1'b1;
        end
    end

    // Saturating count of bubbled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign freeze_all      = w_freeze_all;
    assign flush_front     = w_flush;
    assign freeze_front    = w_bubble;
    assign bubble_id       = w_bubble;
    assign mem_timeout_err = !rst && r_timeout_err;
    assign stall_cnt       = rst ? '0 : r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl. Expectations
//               follow the FORWARDING_EN build option when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

`ifdef FORWARDING_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_src_valid, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic        branch_taken, mem_req, mem_ready;
    logic        freeze_front, bubble_id, flush_front, freeze_all, mem_timeout_err;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src_valid(id_src_valid), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_front(freeze_front), .bubble_id(bubble_id),
        .flush_front(flush_front), .freeze_all(freeze_all),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_src_valid = 1'b0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load-use on R3 in EXE: a hazard in both builds
    task automatic set_load_use();
        exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        id_src1 = 4'd3; id_src_valid = 1'b1;
    endtask

    // Inputs already driven: check the cycle's hazard outputs, then the count
    task automatic run_hazard(input string tag, input logic exp_bub);
        @(negedge clk);
        check({tag, ".freeze_front"}, freeze_front, exp_bub);
        check({tag, ".bubble_id"}, bubble_id, exp_bub);
        tick();
        idle();
        if (exp_bub) exp_stall++;
        @(negedge clk);
        check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        // Reset held with every kind of request active: all outputs low
        mem_req = 1'b1; branch_taken = 1'b1; set_load_use();
        tick();
        @(negedge clk);
        check("rst.freeze_all", freeze_all, 0);
        check("rst.flush_front", flush_front, 0);
        check("rst.freeze_front", freeze_front, 0);
        check("rst.bubble_id", bubble_id, 0);
        check("rst.stall_cnt", stall_cnt, 0);
        check("rst.timeout_err", mem_timeout_err, 0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("post_rst.freeze_all", freeze_all, 0);
        check("post_rst.stall_cnt", stall_cnt, 0);
        tick();

        // EXE ALU producer: stalls only without forwarding
        exe_dest = 4'd3; exe_wb_en = 1'b1; id_src1 = 4'd3; id_src_valid = 1'b1;
        run_hazard("exe_alu", !c_FWD);
        // EXE load producer: stalls in both builds
        set_load_use();
        run_hazard("exe_load", 1'b1);
        // MEM producer on second source
        mem_dest = 4'd5; mem_wb_en = 1'b1; id_src2 = 4'd5; id_two_src = 1'b1;
        id_src1 = 4'd0; id_src_valid = 1'b1;
        run_hazard("mem_src2", !c_FWD);
        // Same but second source not read
        mem_dest = 4'd5; mem_wb_en = 1'b1; id_src2 = 4'd5; id_two_src = 1'b0;
        id_src1 = 4'd0; id_src_valid = 1'b1;
        run_hazard("mem_src2_unused", 1'b0);
        // Load-use but ID reads no source
        set_load_use(); id_src_valid = 1'b0;
        run_hazard("no_src_valid", 1'b0);
        // Load-use pattern but EXE not writing back
        set_load_use(); exe_wb_en = 1'b0;
        run_hazard("no_wb_en", 1'b0);
        // Load-use on second source R7
        exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        id_src1 = 4'd1; id_src2 = 4'd7; id_two_src = 1'b1; id_src_valid = 1'b1;
        run_hazard("exe_load_src2", 1'b1);

        // Branch beats hazard
        set_load_use(); branch_taken = 1'b1;
        @(negedge clk);
        check("br.flush_front", flush_front, 1);
        check("br.freeze_front", freeze_front, 0);
        check("br.bubble_id", bubble_id, 0);
        tick();
        idle();
        @(negedge clk);
        check("br.stall_cnt", stall_cnt, exp_stall);
        check("br.flush_idle", flush_front, 0);
        tick();

        // Four-cycle memory wait with hazard and branch pending underneath
        mem_req = 1'b1; mem_ready = 1'b0; set_load_use(); branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wait4.freeze_all[%0d]", i), freeze_all, 1);
            check($sformatf("wait4.flush[%0d]", i), flush_front, 0);
            check($sformatf("wait4.bubble[%0d]", i), bubble_id, 0);
            tick();
        end
        idle(); mem_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        check("wait4.ready_freeze", freeze_all, 0);
        tick();
        idle();
        @(negedge clk);
        check("wait4.back_in_run", freeze_all, 0);
        check("wait4.timeout_err", mem_timeout_err, 0);
        check("wait4.stall_cnt", stall_cnt, exp_stall);
        tick();

        // Request completing immediately: no freeze, stays in RUN
        mem_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        check("fast_mem.freeze_all", freeze_all, 0);
        tick();
        idle();
        @(negedge clk);
        check("fast_mem.run", freeze_all, 0);
        tick();

        // Timeout: 20 unready cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 15) check("tmo.err_early", mem_timeout_err, 0);
            if (n == 17) check("tmo.err_set", mem_timeout_err, 1);
            if (n == 20) check("tmo.freeze_all", freeze_all, 1);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("tmo.ready_freeze", freeze_all, 0);
        check("tmo.err_ready", mem_timeout_err, 1);
        tick();
        idle();
        @(negedge clk);
        check("tmo.err_sticky", mem_timeout_err, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("tmo.err_in_rst", mem_timeout_err, 0);
        tick();
        rst = 1'b0;
        exp_stall = 0;
        @(negedge clk);
        check("tmo.err_cleared", mem_timeout_err, 0);
        check("tmo.stall_cleared", stall_cnt, exp_stall);
        tick();

        // Stall counter saturation
        set_load_use();
        repeat (65540) tick();
        idle();
        @(negedge clk);
        check("sat.stall_cnt", stall_cnt, 16'hFFFF);
        tick();

        // Reset in the second MEM_WAIT cycle aborts the wait
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait.freeze_in_rst", freeze_all, 0);
        check("rst_wait.stall_in_rst", stall_cnt, 0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rst_wait.freeze_all", freeze_all, 0);
        check("rst_wait.stall_cnt", stall_cnt, 0);
        check("rst_wait.timeout_err", mem_timeout_err, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
